// File: rtl/player_link_pkg.sv
// Shared field layout, lane codes and link-state encoding for the player control byte.
package player_link_pkg;

  // Bit positions inside the received control byte
  localparam int unsigned RST_BIT  = 7;
  localparam int unsigned RSVD_BIT = 6;
  localparam int unsigned FIRE_BIT = 5;
  localparam int unsigned PROJ_BIT = 4;
  localparam int unsigned LANE_MSB = 3;
  localparam int unsigned LANE_LSB = 0;

  // Lane codes; code 0 means "return to centre"
  localparam logic [3:0] LANE_RESET = 4'd0;
  localparam logic [3:0] LANE1      = 4'd1;
  localparam logic [3:0] LANE2      = 4'd2;
  localparam logic [3:0] LANE3      = 4'd3;
  localparam logic [3:0] LANE4      = 4'd4;
  localparam logic [3:0] LANE5      = 4'd5;
  localparam logic [3:0] LANE6      = 4'd6;
  localparam logic [3:0] LANE7      = 4'd7;
  localparam logic [3:0] LANE8      = 4'd8;
  localparam logic [3:0] LANE9      = 4'd9;

  typedef enum logic {
    LINK_DOWN = 1'b0,
    LINK_UP   = 1'b1
  } link_state_e;

  function automatic logic [3:0] lane_code(input logic [7:0] b);
    return b[LANE_MSB:LANE_LSB];
  endfunction

endpackage

// File: rtl/cooldown_timer.sv
// Loadable down-counter that stops at zero and flags when it is idle.
module cooldown_timer #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load takes priority; otherwise count down until zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/player_packet_decoder.sv
// Validates player control bytes from the UART receiver and turns them into
// registered game controls, with fire cooldown and link-timeout tracking.
module player_packet_decoder
  import player_link_pkg::*;
#(
  parameter int unsigned NUM_LANES       = 9,
  parameter int unsigned CENTER_LANE     = 5,
  parameter int unsigned COOLDOWN_CYCLES = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES  = 10_000_000,
  parameter int unsigned ERR_CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 rx_frame_err,
  output logic [3:0]           lane,
  output logic                 proj_type,
  output logic                 fire_pulse,
  output logic                 game_reset_req,
  output logic                 pkt_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 link_up
);

  localparam int unsigned CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CD_W-1:0] CD_RELOAD   = CD_W'(COOLDOWN_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      MAX_CODE    = 4'(NUM_LANES);
  localparam logic [3:0]      CENTER_CODE = 4'(CENTER_LANE);

  link_state_e          r_state;
  link_state_e          w_next_state;
  logic [TO_W-1:0]      r_to_cnt;
  logic [3:0]           r_lane;
  logic                 r_proj_type;
  logic                 r_fire_pulse;
  logic                 r_game_reset_req;
  logic                 r_pkt_err;
  logic [ERR_CNT_W-1:0] r_err_count;
  logic                 r_prev_fire;
  logic                 r_prev_rst;
  logic                 w_link_up;

  logic [3:0] w_code;
  logic       w_accept;
  logic       w_reject;
  logic       w_is_rst;
  logic       w_fire_cand;
  logic       w_cd_zero;
  logic       w_fire;
  logic       w_timeout;

  assign w_code      = lane_code(rx_data);
  assign w_accept    = rx_valid & ~rx_frame_err & ~rx_data[RSVD_BIT] & (w_code <= MAX_CODE);
  assign w_reject    = rx_valid & ~w_accept;
  assign w_is_rst    = rx_data[RST_BIT];
  assign w_fire_cand = w_accept & rx_data[FIRE_BIT] & ~r_prev_fire & ~w_is_rst;
  assign w_fire      = w_fire_cand & w_cd_zero;
  // A valid byte on the final idle cycle keeps the link alive
  assign w_timeout   = (r_state == LINK_UP) & ~w_accept & (r_to_cnt == TO_LAST);

  cooldown_timer #(
    .W (CD_W)
  ) u_fire_cooldown (
    .clk        (clk),
    .rst_n      (rst),
    .i_load     (w_fire),
    .i_load_val (CD_RELOAD),
    .o_zero     (w_cd_zero)
  );

  // Link state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= LINK_DOWN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Link next-state: up on any valid byte, down on timeout
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      LINK_DOWN: if (w_accept)  w_next_state = LINK_UP;
      LINK_UP:   if (w_timeout) w_next_state = LINK_DOWN;
      default:   w_next_state = LINK_DOWN;
    endcase
  end

  // Link output decode
  always_comb begin
    w_link_up = (r_state == LINK_UP);
  end

  // Idle-cycle counter: cleared by valid bytes, runs only while the link is up
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= '0;
    end else if (w_accept || w_timeout || (r_state != LINK_UP)) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Byte decode: pulses, lane/projectile, edge history and error count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lane           <= CENTER_CODE;
      r_proj_type      <= 1'b0;
      r_fire_pulse     <= 1'b0;
      r_game_reset_req <= 1'b0;
      r_pkt_err        <= 1'b0;
      r_err_count      <= '0;
      r_prev_fire      <= 1'b0;
      r_prev_rst       <= 1'b0;
    end else begin
      r_fire_pulse     <= w_fire;
      r_game_reset_req <= w_accept & w_is_rst & ~r_prev_rst;
      r_pkt_err        <= w_reject;
      if (w_reject && (r_err_count != '1)) begin
        r_err_count <= r_err_count + 1'b1;
      end
      if (w_accept) begin
        r_lane      <= (w_is_rst || (w_code == LANE_RESET)) ? CENTER_CODE : w_code;
        r_proj_type <= rx_data[PROJ_BIT];
        r_prev_fire <= rx_data[FIRE_BIT];
        r_prev_rst  <= w_is_rst;
      end else if (w_timeout) begin
        // Forget edge history so the first fire after reconnect is an edge
        r_prev_fire <= 1'b0;
        r_prev_rst  <= 1'b0;
      end
    end
  end

  assign lane           = r_lane;
  assign proj_type      = r_proj_type;
  assign fire_pulse     = r_fire_pulse;
  assign game_reset_req = r_game_reset_req;
  assign pkt_err        = r_pkt_err;
  assign err_count      = r_err_count;
  assign link_up        = w_link_up;

endmodule

// File: tb/tb_player_packet_decoder.sv
// Scoreboard bench for player_packet_decoder with a cycle-count reference model.
module tb_player_packet_decoder;

  localparam int COOL = 8;
  localparam int TMO  = 32;

  typedef struct packed {
    logic [3:0] lane;
    logic       proj;
    logic       fire;
    logic       grr;
    logic       perr;
    logic [7:0] errc;
    logic       link;
  } out_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic [3:0] lane;
  logic       proj_type;
  logic       fire_pulse;
  logic       game_reset_req;
  logic       pkt_err;
  logic [7:0] err_count;
  logic       link_up;

  int vectors    = 0;
  int miscompare = 0;
  out_t sb_q[$];

  // Reference model state (time measured in clock edges)
  longint m_edge, m_last_fire, m_last_valid;
  int     m_lane, m_errc;
  bit     m_proj, m_prev_fire, m_prev_rst, m_link;

  player_packet_decoder #(
    .COOLDOWN_CYCLES (COOL),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_frame_err   (rx_frame_err),
    .lane           (lane),
    .proj_type      (proj_type),
    .fire_pulse     (fire_pulse),
    .game_reset_req (game_reset_req),
    .pkt_err        (pkt_err),
    .err_count      (err_count),
    .link_up        (link_up)
  );

  always #5 clk = ~clk;

  function automatic out_t actual();
    out_t a;
    a = '{lane: lane, proj: proj_type, fire: fire_pulse, grr: game_reset_req,
          perr: pkt_err, errc: err_count, link: link_up};
    return a;
  endfunction

  function automatic out_t reset_vals();
    out_t e;
    e = '{lane: 4'd5, proj: 1'b0, fire: 1'b0, grr: 1'b0, perr: 1'b0, errc: 8'd0, link: 1'b0};
    return e;
  endfunction

  task automatic compare(input string name, input out_t exp);
    out_t act;
    act = actual();
    vectors++;
    if (act !== exp) begin
      miscompare++;
      $display("FAIL %s t=%0t got lane=%0d proj=%0b fire=%0b grr=%0b perr=%0b errc=%0d link=%0b expected lane=%0d proj=%0b fire=%0b grr=%0b perr=%0b errc=%0d link=%0b",
               name, $time, act.lane, act.proj, act.fire, act.grr, act.perr, act.errc, act.link,
               exp.lane, exp.proj, exp.fire, exp.grr, exp.perr, exp.errc, exp.link);
    end
  endtask

  task automatic model_reset();
    m_edge = 0; m_last_fire = -1000; m_last_valid = 0;
    m_lane = 5; m_errc = 0; m_proj = 0;
    m_prev_fire = 0; m_prev_rst = 0; m_link = 0;
  endtask

  // Apply one byte (or idle) for one cycle, predict outputs after the next edge
  task automatic tick(input bit v, input logic [7:0] d, input bit fe);
    out_t e;
    bit acc;
    rx_valid = v; rx_data = d; rx_frame_err = fe;
    m_edge++;
    e = '0;
    acc = v && !fe && !d[6] && (int'(d[3:0]) <= 9);
    if (v && !acc) begin
      e.perr = 1'b1;
      if (m_errc < 255) m_errc++;
    end else if (acc) begin
      m_lane = (d[7] || d[3:0] == 4'd0) ? 5 : int'(d[3:0]);
      m_proj = d[4];
      if (d[7] && !m_prev_rst) e.grr = 1'b1;
      if (d[5] && !m_prev_fire && !d[7] && (m_edge - m_last_fire >= COOL)) begin
        e.fire = 1'b1;
        m_last_fire = m_edge;
      end
      m_prev_fire = d[5]; m_prev_rst = d[7];
      m_last_valid = m_edge; m_link = 1;
    end
    if (!acc && m_link && (m_edge - m_last_valid >= TMO)) begin
      m_link = 0; m_prev_fire = 0; m_prev_rst = 0;
    end
    e.lane = 4'(m_lane); e.proj = m_proj; e.errc = 8'(m_errc); e.link = m_link;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom), 1'($urandom));
  endtask

  // Monitor: outputs are valid every cycle once a prediction is pending
  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) compare("outputs", sb_q.pop_front());
  end

  initial begin
    logic [7:0] b;
    rst = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_frame_err = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    compare("reset_state", reset_vals());
    rst = 1'b1;
    idle(4);

    // Lane codes including centre code
    tick(1, 8'h03, 0); tick(1, 8'h09, 0); tick(1, 8'h00, 0); idle(2);

    // Rejects: bad lane, reserved bit, framing error, then saturation
    tick(1, 8'h0A, 0); tick(1, 8'h43, 0); tick(1, 8'h03, 1); idle(1);
    for (int i = 0; i < 300; i++) tick(1, (i % 2 == 0) ? 8'h4F : 8'h0C, 1'(i % 3 == 0));
    idle(2);

    // Fire edge and cooldown
    tick(1, 8'h25, 0); tick(1, 8'h25, 0); idle(10);
    tick(1, 8'h25, 0); tick(1, 8'h05, 0); idle(1); tick(1, 8'h25, 0);
    tick(1, 8'h05, 0); idle(8); tick(1, 8'h25, 0); idle(2);

    // Remote reset
    tick(1, 8'hA3, 0); tick(1, 8'hA3, 0); tick(1, 8'h23, 0); idle(12);

    // Link timeout, reconnect fire, and byte on the timeout cycle
    tick(1, 8'h05, 0); tick(1, 8'h27, 0); idle(TMO); tick(1, 8'h27, 0);
    tick(1, 8'h03, 0); idle(TMO - 1); tick(1, 8'h04, 0); idle(TMO + 3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      b = 8'($urandom);
      if ($urandom_range(3) != 0) b[6] = 1'b0;
      if ($urandom_range(1) == 0) b[3:0] = 4'($urandom_range(9));
      if ($urandom_range(7) == 0) b[7] = 1'b1;
      tick(1'($urandom_range(1)), b, ($urandom_range(9) == 0));
      if ($urandom_range(19) == 0) idle(int'($urandom_range(TMO + 4)));
    end

    // Reset asserted while a byte is on the bus
    rx_valid = 1'b1; rx_data = 8'h27; rx_frame_err = 1'b0;
    #2 rst = 1'b0;
    #1 compare("async_reset", reset_vals());
    @(negedge clk);
    compare("reset_held", reset_vals());
    rst = 1'b1;
    model_reset();
    tick(1, 8'h27, 0); tick(1, 8'h43, 0); idle(3);

    repeat (3) @(negedge clk);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompare++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompare);
    $finish;
  end

endmodule
